fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Program-counter and fetch controller that sequences the 1K×16 instruction ROM for the pipelined core. It owns the PC, drives the ROM address, and registers the returned word into the IF/ID register. It resolves `JMP in the fetch stage and holds fetch behind conditional branches until execute reports the outcome, so programs no longer need NOP padding after control transfers. It sits between the instruction ROM and the decode stage.

## Interface
- ADDR_W, 10, PC / ROM address width
- INSTR_W, 16, instruction width: 6-bit opcode in [15:10], 10-bit operand in [9:0]
- RESET_PC, 10'd0, first address fetched after reset
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- oAddress  out  ADDR_W  ROM address (registered PC); connects to the ROM iAddress
- iInstruction  in  INSTR_W  ROM data, combinational from oAddress
- iStall  in  1  decode cannot accept; hold PC and the IF/ID register
- iBranchResolve  in  1  execute reports the outcome of the pending conditional branch this cycle
- iBranchTaken  in  1  outcome; qualified by iBranchResolve
- oInstruction  out  INSTR_W  IF/ID instruction register
- oInstrPC  out  ADDR_W  address of oInstruction
- oValid  out  1  oInstruction is a real instruction, not an inserted bubble
- oBranchWait  out  1  high while in BR_WAIT
- oBubbleCount  out  16  saturating count of bubbles inserted by BR_WAIT

## Operation
- Opcode classes, decoded from iInstruction[15:10]:
  - JMP: `JMP.
  - BR: the conditional-branch group Bxxx defined in Defintions.v (includes `BANE, `BBMI, `BBCS).
  - SEQ: everything else.
- JMP target: operand[9:0], absolute.
- BR target:
  - operand[6] = 1: target = PC − operand[5:0].
  - operand[6] = 0: target = PC + operand[5:0].
  - operand[9:7] are ignored. Arithmetic is modulo 2^ADDR_W.
  - Example: PC 13, operand {4'd0,6'd5} gives 18. PC 22, operand {4'd1,6'd12} gives 10.
- Sequential PC increment wraps from 1023 to 0.
- State machine, 2 states:
  - RUN, SEQ fetched: PC <= PC+1. IF/ID <= {iInstruction, PC}, oValid <= 1.
  - RUN, JMP fetched: PC <= operand. JMP is consumed; IF/ID <= NOP, oValid <= 0. Zero-cycle redirect.
  - RUN, BR fetched:
    - IF/ID <= {branch, PC}, oValid <= 1.
    - Latch target and fall-through (PC+1) internally; PC holds.
    - Go to BR_WAIT.
  - BR_WAIT, each cycle:
    - IF/ID <= NOP, oValid <= 0. oBubbleCount increments and saturates at 16'hFFFF.
    - On iBranchResolve: PC <= iBranchTaken ? target : fall-through, then go to RUN.
- iStall high (any state):
  - PC, IF/ID, oValid and oBubbleCount hold.
  - In BR_WAIT, iBranchResolve is still accepted: PC redirects and state returns to RUN while IF/ID holds.
- iBranchResolve in RUN is ignored (no PC change, no error).
- NOP encoding: {`NOP, 10'd0}.

## Timing
- Reset values (asserted asynchronously):
  - PC/oAddress = RESET_PC.
  - oInstruction = {`NOP, 10'd0}, oInstrPC = 0, oValid = 0.
  - oBranchWait = 0, oBubbleCount = 0, state RUN.
- Reset mid-BR_WAIT discards the pending branch.
- First fetch: RESET_PC is on oAddress during reset. Its word appears on oInstruction after the first rising edge with Reset high.
- Fetch latency: address in cycle n gives oInstruction/oInstrPC valid in cycle n+1. Throughput is 1 instruction/cycle in RUN without stall.
- JMP: the target is on oAddress the cycle after the JMP is on oAddress. One bubble slot is emitted.
- BR:
  - Branch on oAddress in cycle n; branch on oInstruction in n+1.
  - Bubbles are emitted from n+2 until the resolve cycle r, inclusive.
  - The redirected address is on oAddress in r+1.
- oBranchWait is registered; high exactly in BR_WAIT cycles.
- All outputs are registered; there is no combinational path from iStall/iBranch* to any output.

## Test plan
- Reset and straight line: release reset with ROM 0..9 as SEQ.
  - oAddress 0,1,2,… per cycle.
  - oInstrPC follows one cycle later, oValid = 1.
  - oBubbleCount = 0.
- JMP: `JMP 26 at address 17.
  - oAddress goes 17 then 26.
  - One oValid = 0 slot.
  - oInstrPC sequence …16, (bubble), 26.
- Forward taken branch: `BBMI {4'd0,6'd5} at 13, resolve taken 3 cycles later.
  - oInstrPC = 13 valid, then 3 bubbles.
  - oAddress = 18; oBubbleCount = 3.
- Backward branch and not taken:
  - `BBMI {4'd1,6'd12} at 22, taken: next address 10.
  - Same branch not taken: next address 23.
  - `BBCS {4'd0,6'd5} at 50, taken: next address 55.
- Stall interactions:
  - iStall held 4 cycles in RUN: oAddress, oInstruction, oValid and oBubbleCount frozen.
  - iStall plus iBranchResolve in BR_WAIT: PC redirects, IF/ID holds.
  - Stray iBranchResolve in RUN: no effect.
- Wrap and reset:
  - SEQ at 1023 gives next address 0.
  - BR at 2 with {4'd1,6'd5} taken gives 1021.
  - Reset asserted mid-BR_WAIT: all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller: sequences the instruction ROM, resolves
// JMP in fetch and parks behind conditional branches until execute resolves them.
module fetch_sequencer #(
   parameter int                ADDR_W   = 10,
   parameter int                INSTR_W  = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               Clock,
   input  logic               Reset,
   output logic [ADDR_W-1:0]  oAddress,
   input  logic [INSTR_W-1:0] iInstruction,
   input  logic               iStall,
   input  logic               iBranchResolve,
   input  logic               iBranchTaken,
   output logic [INSTR_W-1:0] oInstruction,
   output logic [ADDR_W-1:0]  oInstrPC,
   output logic               oValid,
   output logic               oBranchWait,
   output logic [15:0]        oBubbleCount
);

   localparam int OPC_LSB = INSTR_W - 6;

   // Opcode encodings shared with the core's decode definitions.
   localparam logic [5:0] OP_NOP  = 6'h00;
   localparam logic [5:0] OP_JMP  = 6'h0F;
   localparam logic [5:0] OP_BAEQ = 6'h10;
   localparam logic [5:0] OP_BANE = 6'h11;
   localparam logic [5:0] OP_BACS = 6'h12;
   localparam logic [5:0] OP_BACC = 6'h13;
   localparam logic [5:0] OP_BAMI = 6'h14;
   localparam logic [5:0] OP_BAPL = 6'h15;
   localparam logic [5:0] OP_BBEQ = 6'h16;
   localparam logic [5:0] OP_BBNE = 6'h17;
   localparam logic [5:0] OP_BBCS = 6'h18;
   localparam logic [5:0] OP_BBCC = 6'h19;
   localparam logic [5:0] OP_BBMI = 6'h1A;
   localparam logic [5:0] OP_BBPL = 6'h1B;

   localparam logic [INSTR_W-1:0] NOP_WORD = {OP_NOP, {OPC_LSB{1'b0}}};
   localparam logic [ADDR_W-1:0]  PC_ONE   = ADDR_W'(1);

   typedef enum logic {
      RUN     = 1'b0,
      BR_WAIT = 1'b1
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] br_target;
   logic [ADDR_W-1:0] br_fall;

   logic [5:0]        opcode;
   logic              is_jmp;
   logic              is_br;
   logic [ADDR_W-1:0] jmp_target;
   logic [ADDR_W-1:0] br_offset;
   logic [ADDR_W-1:0] br_dest;
   logic [ADDR_W-1:0] pc_next_seq;

   assign opcode      = iInstruction[INSTR_W-1:OPC_LSB];
   assign is_jmp      = (opcode == OP_JMP);
   assign jmp_target  = iInstruction[ADDR_W-1:0];
   assign pc_next_seq = oAddress + PC_ONE;

   always_comb begin
      is_br = 1'b0;
      case (opcode)
         OP_BAEQ, OP_BANE, OP_BACS, OP_BACC, OP_BAMI, OP_BAPL,
         OP_BBEQ, OP_BBNE, OP_BBCS, OP_BBCC, OP_BBMI, OP_BBPL: is_br = 1'b1;
         default: is_br = 1'b0;
      endcase
   end

   // Sign-magnitude displacement: bit 6 selects direction, bits 9:7 are don't-care.
   assign br_offset = {{(ADDR_W-6){1'b0}}, iInstruction[5:0]};
   assign br_dest   = iInstruction[6] ? (oAddress - br_offset) : (oAddress + br_offset);

   assign oBranchWait = (state == BR_WAIT);

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state        <= RUN;
         oAddress     <= RESET_PC;
         oInstruction <= NOP_WORD;
         oInstrPC     <= '0;
         oValid       <= 1'b0;
         oBubbleCount <= '0;
         br_target    <= '0;
         br_fall      <= '0;
      end else begin
         case (state)
            RUN: begin
               if (!iStall) begin
                  if (is_jmp) begin
                     oAddress     <= jmp_target;
                     oInstruction <= NOP_WORD;
                     oValid       <= 1'b0;
                  end else if (is_br) begin
                     oInstruction <= iInstruction;
                     oInstrPC     <= oAddress;
                     oValid       <= 1'b1;
                     br_target    <= br_dest;
                     br_fall      <= pc_next_seq;
                     state        <= BR_WAIT;
                  end else begin
                     oAddress     <= pc_next_seq;
                     oInstruction <= iInstruction;
                     oInstrPC     <= oAddress;
                     oValid       <= 1'b1;
                  end
               end
            end
            BR_WAIT: begin
               if (!iStall) begin
                  oInstruction <= NOP_WORD;
                  oValid       <= 1'b0;
                  if (oBubbleCount != 16'hFFFF) oBubbleCount <= oBubbleCount + 16'd1;
               end
               // Resolution is honoured even under stall; IF/ID simply keeps its word.
               if (iBranchResolve) begin
                  oAddress <= iBranchTaken ? br_target : br_fall;
                  state    <= RUN;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: ROM model, directed fetch/branch/stall scenarios and
// a scoreboard of the instruction stream delivered to decode.
module tb_fetch_sequencer;

   localparam logic [5:0] OP_NOP  = 6'h00;
   localparam logic [5:0] OP_SEQ  = 6'h05;
   localparam logic [5:0] OP_JMP  = 6'h0F;
   localparam logic [5:0] OP_BANE = 6'h11;
   localparam logic [5:0] OP_BBCS = 6'h18;
   localparam logic [5:0] OP_BBMI = 6'h1A;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [9:0]  oAddress;
   logic [15:0] iInstruction;
   logic        iStall = 1'b0;
   logic        iBranchResolve = 1'b0;
   logic        iBranchTaken = 1'b0;
   logic [15:0] oInstruction;
   logic [9:0]  oInstrPC;
   logic        oValid;
   logic        oBranchWait;
   logic [15:0] oBubbleCount;

   logic [15:0] rom [1024];
   logic [26:0] exp_q[$];
   logic [26:0] mon_exp;
   int          total = 0;
   int          bad = 0;

   fetch_sequencer dut (
      .Clock         (Clock),
      .Reset         (Reset),
      .oAddress      (oAddress),
      .iInstruction  (iInstruction),
      .iStall        (iStall),
      .iBranchResolve(iBranchResolve),
      .iBranchTaken  (iBranchTaken),
      .oInstruction  (oInstruction),
      .oInstrPC      (oInstrPC),
      .oValid        (oValid),
      .oBranchWait   (oBranchWait),
      .oBubbleCount  (oBubbleCount)
   );

   always #5 Clock = ~Clock;

   assign iInstruction = rom[oAddress];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Decode consumes the IF/ID word in any cycle it is valid and not stalled.
   always @(negedge Clock) begin
      if (Reset && oValid && !iStall) begin
         mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 27'd0;
         chk("stream", {5'd0, 1'b1, oInstrPC, oInstruction}, {5'd0, mon_exp});
      end
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic init_rom();
      for (int a = 0; a < 1024; a++) rom[a] = {OP_SEQ, 10'(a)};
   endtask

   task automatic push(input logic [9:0] pc);
      exp_q.push_back({1'b1, pc, rom[pc]});
   endtask

   task automatic do_reset();
      Reset = 1'b0;
      iStall = 1'b0;
      iBranchResolve = 1'b0;
      iBranchTaken = 1'b0;
      #2;
      chk("rst_addr", oAddress, 0);
      chk("rst_instr", oInstruction, {OP_NOP, 10'd0});
      chk("rst_ipc", oInstrPC, 0);
      chk("rst_valid", oValid, 0);
      chk("rst_bwait", oBranchWait, 0);
      chk("rst_bubbles", oBubbleCount, 0);
      exp_q.delete();
      repeat (2) @(posedge Clock);
      #1;
      Reset = 1'b1;
   endtask

   task automatic end_seg();
      @(negedge Clock);
      #1;
      chk("sb_drain", exp_q.size(), 0);
   endtask

   task automatic br_case(input logic [9:0] bpc, input logic [5:0] op, input logic [9:0] opnd,
                          input logic taken, input int waitc, input logic [9:0] exp_next);
      init_rom();
      rom[0] = {OP_JMP, bpc};
      rom[bpc] = {op, opnd};
      do_reset();
      push(bpc);
      push(exp_next);
      push(exp_next + 10'd1);
      tick();
      chk("br_addr", oAddress, bpc);
      tick();
      chk("br_wait", oBranchWait, 1);
      chk("br_hold", oAddress, bpc);
      repeat (waitc - 1) tick();
      iBranchResolve = 1'b1;
      iBranchTaken = taken;
      tick();
      iBranchResolve = 1'b0;
      iBranchTaken = 1'b0;
      chk("br_next", oAddress, exp_next);
      chk("br_bubbles", oBubbleCount, waitc);
      chk("br_done", oBranchWait, 0);
      tick();
      tick();
      end_seg();
   endtask

   initial begin
      Reset = 1'b1;
      #1;

      // Straight line then JMP 26 at 17.
      init_rom();
      rom[17] = {OP_JMP, 10'd26};
      do_reset();
      for (int p = 0; p <= 16; p++) push(10'(p));
      for (int p = 26; p <= 29; p++) push(10'(p));
      chk("seq_addr0", oAddress, 0);
      for (int i = 1; i <= 17; i++) begin
         tick();
         chk("seq_addr", oAddress, i);
      end
      tick();
      chk("jmp_addr", oAddress, 26);
      chk("jmp_bubble", oValid, 0);
      for (int i = 27; i <= 30; i++) begin
         tick();
         chk("jmp_seq", oAddress, i);
      end
      chk("seq_bubbles", oBubbleCount, 0);
      end_seg();

      // Conditional branches: forward, backward, not taken, other opcode, wrap, ignored bits.
      br_case(10'd13, OP_BBMI, {4'd0, 6'd5},  1'b1, 3, 10'd18);
      br_case(10'd22, OP_BBMI, {4'd1, 6'd12}, 1'b1, 2, 10'd10);
      br_case(10'd22, OP_BBMI, {4'd1, 6'd12}, 1'b0, 1, 10'd23);
      br_case(10'd50, OP_BBCS, {4'd0, 6'd5},  1'b1, 4, 10'd55);
      br_case(10'd2,  OP_BANE, {4'd1, 6'd5},  1'b1, 2, 10'd1021);
      br_case(10'd40, OP_BANE, {4'b1110, 6'd7}, 1'b1, 1, 10'd47);

      // Sequential wrap 1023 -> 0.
      init_rom();
      rom[0] = {OP_JMP, 10'd1021};
      do_reset();
      push(10'd1021);
      push(10'd1022);
      push(10'd1023);
      push(10'd1021);
      repeat (4) tick();
      chk("wrap_addr", oAddress, 0);
      tick();
      chk("wrap_jmp", oAddress, 1021);
      tick();
      end_seg();

      // Stall held 4 cycles in RUN, then a stray resolve.
      init_rom();
      do_reset();
      for (int p = 0; p <= 9; p++) push(10'(p));
      repeat (5) tick();
      iStall = 1'b1;
      repeat (4) begin
         tick();
         chk("stall_addr", oAddress, 5);
         chk("stall_ipc", oInstrPC, 4);
         chk("stall_instr", oInstruction, {OP_SEQ, 10'd4});
         chk("stall_valid", oValid, 1);
         chk("stall_bubbles", oBubbleCount, 0);
      end
      iStall = 1'b0;
      tick();
      chk("unstall_addr", oAddress, 6);
      iBranchResolve = 1'b1;
      iBranchTaken = 1'b1;
      tick();
      iBranchResolve = 1'b0;
      iBranchTaken = 1'b0;
      chk("stray_addr", oAddress, 7);
      chk("stray_bwait", oBranchWait, 0);
      repeat (3) tick();
      end_seg();

      // Resolve under stall in BR_WAIT: PC redirects, IF/ID holds.
      init_rom();
      rom[0] = {OP_JMP, 10'd30};
      rom[30] = {OP_BBMI, 4'd0, 6'd4};
      do_reset();
      push(10'd30);
      push(10'd34);
      push(10'd35);
      tick();
      tick();
      chk("sr_wait", oBranchWait, 1);
      iStall = 1'b1;
      iBranchResolve = 1'b1;
      iBranchTaken = 1'b1;
      tick();
      iBranchResolve = 1'b0;
      iBranchTaken = 1'b0;
      chk("sr_addr", oAddress, 34);
      chk("sr_ipc", oInstrPC, 30);
      chk("sr_valid", oValid, 1);
      chk("sr_instr", oInstruction, {OP_BBMI, 4'd0, 6'd4});
      chk("sr_bwait", oBranchWait, 0);
      chk("sr_bubbles", oBubbleCount, 0);
      iStall = 1'b0;
      tick();
      tick();
      end_seg();

      // Asynchronous reset in the middle of BR_WAIT.
      init_rom();
      rom[0] = {OP_JMP, 10'd60};
      rom[60] = {OP_BBCS, 4'd0, 6'd3};
      do_reset();
      push(10'd60);
      repeat (3) tick();
      chk("mid_bwait", oBranchWait, 1);
      chk("mid_bubbles", oBubbleCount, 1);
      do_reset();
      chk("post_addr0", oAddress, 0);
      tick();
      chk("post_addr", oAddress, 60);
      chk("post_bwait", oBranchWait, 0);
      chk("post_bubbles", oBubbleCount, 0);
      end_seg();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
